// File: rtl/data_sram_like_bridge.sv
// data_sram_like_bridge: turns the MEM stage's single-cycle data access into
// an sram-like split transaction (req/addr_ok, then data_ok), generates the
// MEM-stage stall, holds the returned read word, and drains responses of
// accesses cancelled by an exception.
module data_sram_like_bridge (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemEnableM,
  input  logic [3:0]  MemWenM,
  input  logic [31:0] MemAddrM,
  input  logic [31:0] TWriteDataM,
  input  logic        PipeStallM,
  input  logic        CancelM,
  output logic [31:0] ReadDataM,
  output logic        DataStallM,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic        discard_q, discard_d;
  logic [31:0] rdata_q, rdata_d;
  logic        lat_wr_q, lat_wr_d;
  logic [1:0]  lat_size_q, lat_size_d;
  logic [31:0] lat_addr_q, lat_addr_d;
  logic [31:0] lat_wdata_q, lat_wdata_d;

  logic        in_wr;
  logic [1:0]  in_size;
  logic [31:0] in_addr;
  logic        issue;
  logic        drop_now;

  // Request attributes derived straight from the MEM-stage inputs.
  always_comb begin
    in_wr = |MemWenM;
    if (in_wr) begin
      unique case (MemWenM)
        4'b1111:          in_size = 2'd2;
        4'b0011, 4'b1100: in_size = 2'd1;
        default:          in_size = 2'd0;
      endcase
      in_addr = MemAddrM;
    end else begin
      in_size = 2'd2;
      in_addr = {MemAddrM[31:2], 2'b00};
    end
    issue    = (state_q == S_IDLE) & MemEnableM & ~CancelM & ~discard_q;
    // A cancel arriving in the same cycle as the response drops it at once.
    drop_now = discard_q | CancelM;
  end

  // State register and all held transaction context.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      discard_q   <= 1'b0;
      rdata_q     <= '0;
      lat_wr_q    <= 1'b0;
      lat_size_q  <= '0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      discard_q   <= discard_d;
      rdata_q     <= rdata_d;
      lat_wr_q    <= lat_wr_d;
      lat_size_q  <= lat_size_d;
      lat_addr_q  <= lat_addr_d;
      lat_wdata_q <= lat_wdata_d;
    end
  end

  // Next-state, discard tracking, attribute latch and read-data capture.
  always_comb begin
    state_d     = state_q;
    discard_d   = discard_q;
    rdata_d     = rdata_q;
    lat_wr_d    = lat_wr_q;
    lat_size_d  = lat_size_q;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (issue) begin
          lat_wr_d    = in_wr;
          lat_size_d  = in_size;
          lat_addr_d  = in_addr;
          lat_wdata_d = TWriteDataM;
          state_d     = data_addr_ok ? S_WAIT : S_REQ;
        end
      end
      S_REQ: begin
        discard_d = drop_now;
        if (data_addr_ok) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (data_data_ok) begin
          if (~lat_wr_q & ~drop_now) rdata_d = data_rdata;
          discard_d = 1'b0;
          state_d   = drop_now ? S_IDLE : S_DONE;
        end else begin
          discard_d = drop_now;
        end
      end
      S_DONE: begin
        if (CancelM | ~PipeStallM) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bus request, attribute mux, stall and read-data outputs.
  always_comb begin
    data_req = ~rst & (issue | (state_q == S_REQ));
    if (state_q == S_IDLE) begin
      data_wr    = in_wr;
      data_size  = in_size;
      data_addr  = in_addr;
      data_wdata = TWriteDataM;
    end else begin
      data_wr    = lat_wr_q;
      data_size  = lat_size_q;
      data_addr  = lat_addr_q;
      data_wdata = lat_wdata_q;
    end
    DataStallM = ~rst & ((MemEnableM & ~CancelM & (state_q != S_DONE)) | discard_q);
    ReadDataM  = rdata_q;
  end

endmodule

// File: tb/tb_data_sram_like_bridge.sv
// Bench for data_sram_like_bridge: directed scenarios with literal
// expectations, then randomized pipeline/bus traffic against a
// transaction-level reference model.
module tb_data_sram_like_bridge;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, MemEnableM, PipeStallM, CancelM;
  logic [3:0]  MemWenM;
  logic [31:0] MemAddrM, TWriteDataM, data_rdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] ReadDataM, data_addr, data_wdata;
  logic        DataStallM, data_req, data_wr;
  logic [1:0]  data_size;

  int checks   = 0;
  int failures = 0;
  bit armed    = 1'b0;

  data_sram_like_bridge dut (
    .clk          (clk),
    .rst          (rst),
    .MemEnableM   (MemEnableM),
    .MemWenM      (MemWenM),
    .MemAddrM     (MemAddrM),
    .TWriteDataM  (TWriteDataM),
    .PipeStallM   (PipeStallM),
    .CancelM      (CancelM),
    .ReadDataM    (ReadDataM),
    .DataStallM   (DataStallM),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: bus-transaction view of the bridge.
  bit          m_unacc, m_infl, m_hold, m_drop;
  logic [31:0] m_rdata;
  logic        m_wr;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wdata;
  bit          m_idle, e_req, e_stall;
  logic        e_wr;
  logic [1:0]  e_size;
  logic [31:0] e_addr, e_wdata;

  function automatic logic [1:0] size_of(input logic [3:0] wen);
    int n;
    n = $countones(wen);
    if (n == 0 || n == 4) return 2'd2;
    if (n == 2) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [31:0] addr_of(input logic [3:0] wen, input logic [31:0] a);
    if (wen == 4'b0000) return a & 32'hFFFF_FFFC;
    return a;
  endfunction

  // Compare DUT to model every cycle, then advance the model on the edge.
  initial begin
    m_unacc = 0; m_infl = 0; m_hold = 0; m_drop = 0; m_rdata = '0;
    m_wr = 0; m_size = '0; m_addr = '0; m_wdata = '0;
    forever begin
      @(negedge clk);
      #2;
      m_idle  = !(m_unacc || m_infl || m_hold);
      e_req   = !rst && ((m_idle && MemEnableM && !CancelM && !m_drop) || m_unacc);
      e_stall = !rst && ((MemEnableM && !CancelM && !m_hold) || m_drop);
      if (m_idle) begin
        e_wr = |MemWenM; e_size = size_of(MemWenM);
        e_addr = addr_of(MemWenM, MemAddrM); e_wdata = TWriteDataM;
      end else begin
        e_wr = m_wr; e_size = m_size; e_addr = m_addr; e_wdata = m_wdata;
      end
      if (armed) begin
        chk("m_req", data_req, e_req);
        chk("m_stall", DataStallM, e_stall);
        chk("m_rdata", ReadDataM, m_rdata);
        if (e_req) begin
          chk("m_wr", data_wr, e_wr);
          chk("m_size", data_size, e_size);
          chk("m_addr", data_addr, e_addr);
          chk("m_wdata", data_wdata, e_wdata);
        end
      end
      @(posedge clk);
      if (rst) begin
        m_unacc = 0; m_infl = 0; m_hold = 0; m_drop = 0; m_rdata = '0;
      end else if (m_idle) begin
        if (e_req) begin
          m_wr = e_wr; m_size = e_size; m_addr = e_addr; m_wdata = e_wdata;
          if (data_addr_ok) m_infl = 1; else m_unacc = 1;
        end
      end else if (m_unacc) begin
        m_drop = m_drop || CancelM;
        if (data_addr_ok) begin m_unacc = 0; m_infl = 1; end
      end else if (m_infl) begin
        if (data_data_ok) begin
          if (!(m_drop || CancelM)) begin
            if (!m_wr) m_rdata = data_rdata;
            m_hold = 1;
          end
          m_drop = 0; m_infl = 0;
        end else begin
          m_drop = m_drop || CancelM;
        end
      end else if (m_hold) begin
        if (CancelM || !PipeStallM) m_hold = 0;
      end
    end
  end

  task automatic quiet();
    MemEnableM = 0; MemWenM = '0; MemAddrM = '0; TWriteDataM = '0;
    PipeStallM = 0; CancelM = 0; data_addr_ok = 0; data_data_ok = 0; data_rdata = '0;
  endtask

  logic [3:0] wens [9] = '{4'h0, 4'h0, 4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8};
  int  stall_cnt;
  bit  new_instr, outst, req_s, stall_s;

  initial begin
    rst = 1; quiet(); MemEnableM = 1;
    @(negedge clk); #2;
    chk("req_during_rst", data_req, 0);
    chk("stall_during_rst", DataStallM, 0);
    @(posedge clk); armed = 1;
    @(negedge clk); MemEnableM = 0;
    @(negedge clk); rst = 0; #2;
    chk("reset_rdata", ReadDataM, 0);
    chk("reset_req", data_req, 0);
    chk("reset_stall", DataStallM, 0);

    // Best-case word read.
    @(negedge clk); MemEnableM = 1; MemAddrM = 32'h1000_0004; data_addr_ok = 1; #2;
    chk("rd_req", data_req, 1); chk("rd_size", data_size, 2);
    chk("rd_addr", data_addr, 32'h1000_0004); chk("rd_wr", data_wr, 0);
    chk("rd_stall0", DataStallM, 1);
    @(negedge clk); data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'hDEAD_BEEF; #2;
    chk("rd_stall1", DataStallM, 1); chk("rd_req1", data_req, 0);
    @(negedge clk); data_data_ok = 0; #2;
    chk("rd_stall2", DataStallM, 0); chk("rd_data", ReadDataM, 32'hDEAD_BEEF);
    @(negedge clk); quiet(); #2;
    chk("rd_data_after", ReadDataM, 32'hDEAD_BEEF);

    // Byte store with three addr_ok wait cycles.
    @(negedge clk);
    MemEnableM = 1; MemWenM = 4'b0100; MemAddrM = 32'h2002; TWriteDataM = 32'h00AB_0000;
    stall_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      data_addr_ok = (i == 3); data_data_ok = (i == 4);
      #2;
      if (i < 4) begin
        chk("st_req", data_req, 1); chk("st_wr", data_wr, 1); chk("st_size", data_size, 0);
        chk("st_addr", data_addr, 32'h2002); chk("st_wdata", data_wdata, 32'h00AB_0000);
      end
      if (DataStallM === 1'b1) stall_cnt++;
    end
    chk("st_stall_cycles", stall_cnt, 5);
    chk("st_rdata_kept", ReadDataM, 32'hDEAD_BEEF);
    @(negedge clk); quiet();

    // Hold in DONE while the pipeline is stalled elsewhere.
    @(negedge clk); MemEnableM = 1; MemAddrM = 32'h40; data_addr_ok = 1;
    @(negedge clk); data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'h1234_5678;
    @(negedge clk); data_data_ok = 0; PipeStallM = 1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      #2;
      chk("hold_stall", DataStallM, 0); chk("hold_req", data_req, 0);
      chk("hold_rdata", ReadDataM, 32'h1234_5678);
    end
    @(negedge clk); PipeStallM = 0; #2;
    chk("hold_release_stall", DataStallM, 0);
    @(negedge clk); quiet();

    // Cancel in WAIT followed by a new read.
    @(negedge clk); MemEnableM = 1; MemAddrM = 32'h50; data_addr_ok = 1; #2;
    chk("cx_req", data_req, 1);
    @(negedge clk); data_addr_ok = 0; CancelM = 1; #2;
    chk("cx_stall_cancel", DataStallM, 0);
    @(negedge clk); CancelM = 0; MemAddrM = 32'h3000; #2;
    chk("cx_req_blocked", data_req, 0); chk("cx_stall_drain", DataStallM, 1);
    @(negedge clk); data_data_ok = 1; data_rdata = 32'hBAD0_BAD0; #2;
    chk("cx_req_at_dok", data_req, 0); chk("cx_stall_at_dok", DataStallM, 1);
    @(negedge clk); data_data_ok = 0; data_addr_ok = 1; #2;
    chk("cx_new_req", data_req, 1); chk("cx_new_addr", data_addr, 32'h3000);
    chk("cx_rdata_kept", ReadDataM, 32'h1234_5678);
    @(negedge clk); data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'hCAFE_0001;
    @(negedge clk); data_data_ok = 0; #2;
    chk("cx_new_rdata", ReadDataM, 32'hCAFE_0001); chk("cx_new_stall", DataStallM, 0);
    @(negedge clk); quiet();

    // Reset pulsed in WAIT.
    @(negedge clk); MemEnableM = 1; MemAddrM = 32'h60; data_addr_ok = 1;
    @(negedge clk); data_addr_ok = 0; MemEnableM = 0; rst = 1; #2;
    chk("rw_req_in_rst", data_req, 0);
    @(negedge clk); rst = 0; #2;
    chk("rw_req", data_req, 0); chk("rw_rdata", ReadDataM, 0); chk("rw_stall", DataStallM, 0);

    // Unaligned half read is issued as an aligned word read.
    @(negedge clk); MemEnableM = 1; MemAddrM = 32'h6; data_addr_ok = 1; #2;
    chk("hr_addr", data_addr, 32'h4); chk("hr_size", data_size, 2); chk("hr_wr", data_wr, 0);
    @(negedge clk); data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'h0000_BEEF;
    @(negedge clk); data_data_ok = 0; #2;
    chk("hr_rdata", ReadDataM, 32'h0000_BEEF);
    @(negedge clk); quiet();

    // Randomized pipeline and bus slave.
    new_instr = 1; outst = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (new_instr) begin
        MemEnableM  = ($urandom_range(0, 3) != 0);
        MemWenM     = wens[$urandom_range(0, 8)];
        MemAddrM    = $urandom;
        TWriteDataM = $urandom;
      end
      rst          = ($urandom_range(0, 199) == 0);
      CancelM      = ($urandom_range(0, 15) == 0);
      PipeStallM   = ($urandom_range(0, 3) == 0);
      data_addr_ok = ($urandom_range(0, 1) == 1);
      data_data_ok = outst && ($urandom_range(0, 2) != 0);
      data_rdata   = $urandom;
      #2;
      req_s = (data_req === 1'b1); stall_s = (DataStallM === 1'b1);
      @(posedge clk);
      if (rst) begin
        outst = 0; new_instr = 1;
      end else begin
        if (data_data_ok) outst = 0;
        if (req_s && data_addr_ok) outst = 1;
        new_instr = CancelM || (!stall_s && !PipeStallM);
      end
    end

    @(negedge clk); quiet(); rst = 0;
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
